// File: rtl/core_arb_pkg.sv
// rtl/core_arb_pkg.sv - shared limits, index type, arbiter state and selection helpers
package core_arb_pkg;

  localparam int MAX_MASTERS           = 4;
  localparam int MAX_OUTSTANDING_LIMIT = 4;

  typedef logic [1:0] master_idx_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

  // First asserted request strictly after 'last', wrapping at n requesters
  function automatic master_idx_t rr_select(input logic [MAX_MASTERS-1:0] req,
                                            input master_idx_t            last,
                                            input logic [2:0]             n);
    master_idx_t sel;
    logic        found;
    logic [2:0]  idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_MASTERS; i++) begin
      idx = {1'b0, last} + 3'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (3'(i) <= n) && req[idx[1:0]]) begin
        sel   = idx[1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic master_idx_t fixed_select(input logic [MAX_MASTERS-1:0] req);
    master_idx_t sel;
    sel = '0;
    for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) sel = 2'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/core_arb_id_fifo.sv
// rtl/core_arb_id_fifo.sv - in-order FIFO of requester indices for in-flight transactions
module core_arb_id_fifo
  import core_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  master_idx_t push_idx,
  input  logic        pop,
  output master_idx_t head,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count
);

  master_idx_t mem [MAX_OUTSTANDING_LIMIT];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic        do_push;
  logic        do_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign full    = (count == 3'(DEPTH));
  assign empty   = (count == 3'd0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 3'd1;
      else if (!do_push && do_pop) count <= count - 3'd1;
    end
  end

  // Storage needs no reset: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/core_port_arbiter.sv
// rtl/core_port_arbiter.sv - shares one req/gnt/rvalid port among requesters; CORE_ARB_RR_EN selects round-robin over fixed priority
module core_port_arbiter
  import core_arb_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_MASTERS-1:0]         m_req_i,
  output logic [N_MASTERS-1:0]         m_gnt_o,
  output logic [N_MASTERS-1:0]         m_rvalid_o,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]         m_we_i,
  input  logic [N_MASTERS*4-1:0]       m_be_i,
  input  logic [N_MASTERS*32-1:0]      m_wdata_i,
  output logic [N_MASTERS*32-1:0]      m_rdata_o,
  output logic                         s_req_o,
  input  logic                         s_gnt_i,
  input  logic                         s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]        s_addr_o,
  output logic                         s_we_o,
  output logic [3:0]                   s_be_o,
  output logic [31:0]                  s_wdata_o,
  input  logic [31:0]                  s_rdata_i,
  output logic                         err_o
);

  logic [MAX_MASTERS-1:0] req_ext;
  logic                   any_req;
  master_idx_t            arb_sel;
  master_idx_t            sel;
  logic                   handshake;
  logic                   rsp_valid;

  arb_state_t             state_q, state_d;
  master_idx_t            lock_idx_q, lock_idx_d;

  master_idx_t            fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2:0]             fifo_count;

  assign req_ext = MAX_MASTERS'(m_req_i);
  assign any_req = |m_req_i;

`ifdef CORE_ARB_RR_EN
  master_idx_t last_grant;

  assign arb_sel = rr_select(req_ext, last_grant, 3'(N_MASTERS));

  // Reset to the last index so requester 0 wins the first round
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          last_grant <= 2'(N_MASTERS - 1);
    else if (handshake) last_grant <= sel;
  end
`else
  assign arb_sel = fixed_select(req_ext);
`endif

  // A stalled request keeps its selection so address/control stay stable until granted
  assign sel = (state_q == ARB_LOCKED) ? lock_idx_q : arb_sel;

  // Full blocks new requests even on a same-cycle pop, keeping rvalid off the req path
  assign s_req_o   = any_req && !fifo_full;
  assign handshake = s_req_o && s_gnt_i;
  assign rsp_valid = s_rvalid_i && !fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ARB_OPEN: begin
        if (s_req_o && !s_gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = sel;
        end
      end
      ARB_LOCKED: begin
        if (handshake) state_d = ARB_OPEN;
      end
    endcase
  end

  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = 4'h0;
    s_wdata_o  = 32'h0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (any_req && (sel == 2'(i))) begin
        s_addr_o   = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o     = m_we_i[i];
        s_be_o     = m_be_i[i*4 +: 4];
        s_wdata_o  = m_wdata_i[i*32 +: 32];
        m_gnt_o[i] = handshake;
      end
      if (rsp_valid && (fifo_head == 2'(i))) begin
        m_rvalid_o[i]         = 1'b1;
        m_rdata_o[i*32 +: 32] = s_rdata_i;
      end
    end
  end

  core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (handshake),
    .push_idx (sel),
    .pop      (rsp_valid),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Stray responses are dropped and flagged until reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          err_o <= 1'b0;
    else if (s_rvalid_i && fifo_empty)  err_o <= 1'b1;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_count <= 3'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_core_port_arbiter.sv
// tb/tb_core_port_arbiter.sv - queue-model and directed-vector bench for core_port_arbiter
module tb_core_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int MO = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_gnt, m_rvalid, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*4-1:0]  m_be;
  logic [N*32-1:0] m_wdata, m_rdata;
  logic            s_req, s_gnt, s_rvalid, s_we, err;
  logic [AW-1:0]   s_addr;
  logic [3:0]      s_be;
  logic [31:0]     s_wdata, s_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int q[$];
  int mdl_last = N - 1;
  bit mdl_lock = 1'b0;
  int mdl_lock_idx = 0;
  bit mdl_err = 1'b0;

  logic [1:0] exp_t2 [4];

  core_port_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata),
    .err_o(err)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (mdl_lock) return mdl_lock_idx;
`ifdef CORE_ARB_RR_EN
    for (int k = 1; k <= N; k++) if (m_req[(mdl_last + k) % N]) return (mdl_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (m_req[k]) return k;
`endif
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int s;
    bit full, hs, e_req;
    logic [AW-1:0]   e_addr;
    logic            e_we;
    logic [3:0]      e_be;
    logic [31:0]     e_wdata;
    logic [N-1:0]    e_gnt, e_rv;
    logic [N*32-1:0] e_rdata;
    if (rst) begin
      q.delete();
      mdl_last = N - 1;
      mdl_lock = 1'b0;
      mdl_err  = 1'b0;
    end
    full  = (q.size() >= MO);
    s     = pick();
    e_req = (|m_req) && !full;
    hs    = e_req && s_gnt;
    e_addr = '0; e_we = 1'b0; e_be = 4'h0; e_wdata = 32'h0; e_gnt = '0; e_rv = '0; e_rdata = '0;
    if (s >= 0) begin
      e_addr  = m_addr[s*AW +: AW];
      e_we    = m_we[s];
      e_be    = m_be[s*4 +: 4];
      e_wdata = m_wdata[s*32 +: 32];
      if (hs) e_gnt[s] = 1'b1;
    end
    if (s_rvalid && q.size() > 0) begin
      e_rv[q[0]] = 1'b1;
      e_rdata[q[0]*32 +: 32] = s_rdata;
    end
    check("mdl_s_req", 64'(s_req), 64'(e_req));
    check("mdl_s_addr", 64'(s_addr), 64'(e_addr));
    check("mdl_s_we", 64'(s_we), 64'(e_we));
    check("mdl_s_be", 64'(s_be), 64'(e_be));
    check("mdl_s_wdata", 64'(s_wdata), 64'(e_wdata));
    check("mdl_m_gnt", 64'(m_gnt), 64'(e_gnt));
    check("mdl_m_rvalid", 64'(m_rvalid), 64'(e_rv));
    check("mdl_m_rdata", 64'(m_rdata), 64'(e_rdata));
    check("mdl_err", 64'(err), 64'(mdl_err));
    if (!rst) begin
      if (s_rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else mdl_err = 1'b1;
      end
      if (hs) begin
        q.push_back(s);
        mdl_last = s;
        mdl_lock = 1'b0;
      end else if (e_req) begin
        mdl_lock     = 1'b1;
        mdl_lock_idx = s;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0;
  endtask

  initial begin
`ifdef CORE_ARB_RR_EN
    exp_t2[0] = 2'b10; exp_t2[1] = 2'b01; exp_t2[2] = 2'b10; exp_t2[3] = 2'b01;
`else
    exp_t2[0] = 2'b01; exp_t2[1] = 2'b01; exp_t2[2] = 2'b01; exp_t2[3] = 2'b01;
`endif
    rst = 1'b1;
    idle();
    m_addr = '0; m_we = '0; m_be = '0; m_wdata = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_s_req", 64'(s_req), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_gnt", 64'(m_gnt), 64'h0);
    tick();
    rst = 1'b0;

    // single read from requester 0
    m_req = 2'b01; m_addr = {32'h2000, 32'h1000}; m_be = {4'hF, 4'h3};
    m_wdata = {32'h22, 32'h11}; m_we = 2'b00; s_gnt = 1'b1;
    @(negedge clk);
    check("t1_gnt", 64'(m_gnt), 64'h1);
    check("t1_addr", 64'(s_addr), 64'h1000);
    check("t1_be", 64'(s_be), 64'h3);
    tick(); idle(); tick();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_rvalid", 64'(m_rvalid), 64'h1);
    check("t1_rdata0", 64'(m_rdata[31:0]), 64'hDEADBEEF);
    check("t1_rdata1", 64'(m_rdata[63:32]), 64'h0);
    tick(); idle();

    // both requesting, downstream always granting
    m_req = 2'b11; s_gnt = 1'b1; m_we = 2'b10;
    for (int k = 0; k < 4; k++) begin
      s_rvalid = (k > 0);
      s_rdata  = 32'(k);
      @(negedge clk);
      check("t2_gnt", 64'(m_gnt), 64'(exp_t2[k]));
      if (k == 1) check("t2_rv_first", 64'(m_rvalid), 64'(exp_t2[0]));
      tick();
    end
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55;
    tick(); idle(); m_we = '0;

    // stalled request keeps its selection
    m_addr = {32'hB0, 32'hA0};
    m_req = 2'b01; s_gnt = 1'b0;
    @(negedge clk); check("t3_addr0", 64'(s_addr), 64'hA0);
    tick();
    m_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_lock_addr", 64'(s_addr), 64'hA0);
      check("t3_lock_gnt", 64'(m_gnt), 64'h0);
      tick();
    end
    s_gnt = 1'b1;
    @(negedge clk);
    check("t3_gnt0", 64'(m_gnt), 64'h1);
    check("t3_addr_gnt", 64'(s_addr), 64'hA0);
    tick();
    m_req = 2'b10; s_gnt = 1'b0;
    @(negedge clk); check("t3b_addr1", 64'(s_addr), 64'hB0);
    tick();
    m_req = 2'b11;
    @(negedge clk); check("t3b_lock_addr", 64'(s_addr), 64'hB0);
    tick();
    s_gnt = 1'b1;
    @(negedge clk); check("t3b_gnt1", 64'(m_gnt), 64'h2);
    tick(); idle();
    s_rvalid = 1'b1; s_rdata = 32'h111;
    @(negedge clk);
    check("t3_rv_order0", 64'(m_rvalid), 64'h1);
    check("t3_rdata0", 64'(m_rdata[31:0]), 64'h111);
    tick();
    s_rdata = 32'h222;
    @(negedge clk);
    check("t3_rv_order1", 64'(m_rvalid), 64'h2);
    check("t3_rdata1", 64'(m_rdata[63:32]), 64'h222);
    tick(); idle();

    // FIFO full blocks requests, including on the pop cycle
    m_req = 2'b11; s_gnt = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("t4_full_req", 64'(s_req), 64'h0);
    check("t4_full_gnt", 64'(m_gnt), 64'h0);
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h333;
    @(negedge clk);
    check("t4_pop_req", 64'(s_req), 64'h0);
    check("t4_pop_rv", 64'(m_rvalid), 64'h1);
    tick();
    s_rvalid = 1'b0;
    @(negedge clk);
    check("t4_req_back", 64'(s_req), 64'h1);
    check("t4_gnt_back", 64'(m_gnt), 64'h1);
    tick();
    m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
    tick(); tick(); idle();

    // stray response sets sticky error
    s_rvalid = 1'b1; s_rdata = 32'h999;
    @(negedge clk);
    check("t5_stray_rv", 64'(m_rvalid), 64'h0);
    check("t5_err_before", 64'(err), 64'h0);
    tick(); idle();
    @(negedge clk); check("t5_err_set", 64'(err), 64'h1);
    tick(); tick();
    @(negedge clk); check("t5_err_sticky", 64'(err), 64'h1);

    // reset with two outstanding discards them
    m_req = 2'b01; s_gnt = 1'b1;
    tick(); tick(); idle();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_err", 64'(err), 64'h0);
    check("t6_rst_req", 64'(s_req), 64'h0);
    check("t6_rst_rv", 64'(m_rvalid), 64'h0);
    tick(); tick();
    rst = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h777;
    @(negedge clk); check("t6_late_rv", 64'(m_rvalid), 64'h0);
    tick(); idle();
    @(negedge clk); check("t6_late_err", 64'(err), 64'h1);
    tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
